// File: rtl/ball_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball collision checker: default bitmap geometry,
// bitmap address width and the checker FSM state encoding.
// ---------------------------------------------------------------------------
package ball_pkg;

   // Default obstacle bitmap geometry (one bit per pixel, row-major).
   localparam int BALL_H_RES      = 640;
   localparam int BALL_V_RES      = 480;
   localparam int BALL_MEM_ADDR_W = 19;

   // Collision check sequence: latch the ball, read the left edge pixel,
   // read the right edge pixel, publish the result.
   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      REQ_L,
      WAIT_L,
      REQ_R,
      WAIT_R,
      DONE
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the Clk domain through two flops and
// produces a one-cycle pulse on each rising edge of the synchronised level.
//
// Ports:
//   Clk      - system clock
//   Reset_n  - synchronous active-low reset
//   async_in - asynchronous level (e.g. vsync-derived frame strobe)
//   rise     - one Clk-cycle pulse per rising edge of async_in
// ---------------------------------------------------------------------------
module sync_edge (
   input  logic Clk,
   input  logic Reset_n,
   input  logic async_in,
   output logic rise
);

   // [0] and [1] are the synchroniser; [2] holds the previous synchronised
   // value for edge detection.
   logic [2:0] sync_q;

   // NOTE: reset is sampled on the clock edge, so it lives inside the
   // clocked block rather than in the sensitivity list.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ball_collide.sv
// ---------------------------------------------------------------------------
// ball_collide
// Once per frame, samples the obstacle bitmap at the ball's left edge
// (X-S, Y) and right edge (X+S, Y) and reports whether either pixel is an
// obstacle. Samples that fall outside the bitmap are skipped and count as
// clear. The bitmap is read through a simple request / valid handshake with
// unbounded latency.
//
// Ports:
//   Clk        - system clock
//   Reset_n    - synchronous active-low reset
//   frame_clk  - once-per-frame strobe, asynchronous to Clk
//   BallX/Y    - ball centre position in pixels
//   BallS      - ball half-size in pixels
//   mem_rd     - bitmap read request, held until mem_valid
//   mem_addr   - bitmap read address, Y*H_RES + X
//   mem_valid  - mem_rdata is valid for the outstanding request
//   mem_rdata  - bitmap pixel, 1 = obstacle
//   bit_on     - collision result of the last completed check
//   busy       - a check is in progress
//   overrun    - one-cycle pulse when a frame edge arrives while busy
// ---------------------------------------------------------------------------
module ball_collide
   import ball_pkg::*;
#(
   parameter int H_RES      = BALL_H_RES,
   parameter int V_RES      = BALL_V_RES,
   parameter int MEM_ADDR_W = BALL_MEM_ADDR_W
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  frame_clk,
   input  logic [9:0]            BallX,
   input  logic [9:0]            BallY,
   input  logic [9:0]            BallS,
   output logic                  mem_rd,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic                  mem_valid,
   input  logic                  mem_rdata,
   output logic                  bit_on,
   output logic                  busy,
   output logic                  overrun
);

   // Largest legal pixel coordinates, one bit wider than the ball inputs so
   // that X+S can be range-checked without wrapping.
   localparam logic [10:0] H_MAX = 11'(H_RES - 1);
   localparam logic [10:0] V_MAX = 11'(V_RES - 1);

   state_t     state;
   logic       frame_start;

   // Ball geometry captured in LATCH; everything after LATCH uses these.
   logic [9:0] bx, by, bs;
   logic       right_ok;
   logic       left_hit, right_hit;

   // Range checks on the live inputs, only consumed in LATCH.
   logic        in_left_ok, in_right_ok, in_row_ok;
   logic [9:0]  in_left_x;
   logic [10:0] in_right_x;

   // Sample x coordinates from the captured geometry.
   logic [9:0]  left_x;
   logic [10:0] right_x;

   sync_edge u_sync_edge (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .async_in (frame_clk),
      .rise     (frame_start)
   );

   assign in_left_x   = BallX - BallS;
   assign in_right_x  = {1'b0, BallX} + {1'b0, BallS};
   assign in_row_ok   = ({1'b0, BallY} <= V_MAX);
   // X < S would wrap the subtraction, so it is rejected before the range test.
   assign in_left_ok  = in_row_ok && (BallX >= BallS) && ({1'b0, in_left_x} <= H_MAX);
   assign in_right_ok = in_row_ok && (in_right_x <= H_MAX);

   assign left_x  = bx - bs;
   assign right_x = {1'b0, bx} + {1'b0, bs};

   // Row-major pixel address. Operands are widened to the address width
   // before multiplying so no partial product is truncated.
   function automatic logic [MEM_ADDR_W-1:0] pix_addr(input logic [9:0]  y,
                                                      input logic [10:0] x);
      return MEM_ADDR_W'(y) * MEM_ADDR_W'(H_RES) + MEM_ADDR_W'(x);
   endfunction

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state     <= IDLE;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         bit_on    <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         bx        <= '0;
         by        <= '0;
         bs        <= '0;
         right_ok  <= 1'b0;
         left_hit  <= 1'b0;
         right_hit <= 1'b0;
      end else begin
         // A frame edge outside IDLE (DONE included) is dropped and flagged;
         // the running check carries on untouched.
         overrun <= frame_start && (state != IDLE);

         case (state)
            IDLE: begin
               if (frame_start) begin
                  state <= LATCH;
                  busy  <= 1'b1;
               end
            end

            LATCH: begin
               bx        <= BallX;
               by        <= BallY;
               bs        <= BallS;
               right_ok  <= in_right_ok;
               left_hit  <= 1'b0;
               right_hit <= 1'b0;
               state     <= in_left_ok ? REQ_L : REQ_R;
            end

            REQ_L: begin
               mem_rd   <= 1'b1;
               mem_addr <= pix_addr(by, {1'b0, left_x});
               state    <= WAIT_L;
            end

            // mem_rd/mem_addr hold here until the bitmap answers.
            WAIT_L: begin
               if (mem_valid) begin
                  left_hit <= mem_rdata;
                  mem_rd   <= 1'b0;
                  state    <= REQ_R;
               end
            end

            REQ_R: begin
               if (right_ok) begin
                  mem_rd   <= 1'b1;
                  mem_addr <= pix_addr(by, right_x);
                  state    <= WAIT_R;
               end else begin
                  state <= DONE;
               end
            end

            WAIT_R: begin
               if (mem_valid) begin
                  right_hit <= mem_rdata;
                  mem_rd    <= 1'b0;
                  state     <= DONE;
               end
            end

            DONE: begin
               bit_on <= left_hit | right_hit;
               busy   <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state  <= IDLE;
               mem_rd <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ball_collide.md
BALL_COLLIDE -- requirements
Module: ball_collide

Interface
REQ-001 Parameter H_RES, default 640, SHALL give the bitmap width in pixels.
REQ-002 Parameter V_RES, default 480, SHALL give the bitmap height in pixels.
REQ-003 Parameter MEM_ADDR_W, default 19, SHALL give the bitmap address width.
REQ-004 Clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 frame_clk  input  1  SHALL be the once-per-frame strobe (vsync-derived), asynchronous to Clk.
REQ-007 BallX, BallY  input  10 each  SHALL be the ball centre position in pixels.
REQ-008 BallS  input  10  SHALL be the ball half-size in pixels.
REQ-009 mem_rd  output  1  SHALL request a 1-bit read from the obstacle bitmap.
REQ-010 mem_addr  output  MEM_ADDR_W  SHALL be the read address, computed as Y*H_RES + X.
REQ-011 mem_valid  input  1  SHALL flag that mem_rdata holds valid data for the outstanding request.
REQ-012 mem_rdata  input  1  SHALL be the bitmap pixel: 1 = obstacle.
REQ-013 bit_on  output  1  SHALL be the collision result for the last completed frame, fed back to the ball motion block.
REQ-014 busy  output  1  SHALL be high while a frame check is in progress.
REQ-015 overrun  output  1  SHALL pulse high for one Clk cycle when a frame edge arrives while busy.

Function
REQ-016 frame_clk SHALL pass through a two-flop synchroniser plus edge detect; one rising edge SHALL give a one-cycle frame_start.
REQ-017 FSM states SHALL be IDLE, LATCH, REQ_L, WAIT_L, REQ_R, WAIT_R, DONE.
REQ-018 IDLE -> LATCH on frame_start; LATCH SHALL capture BallX/BallY/BallS into internal registers, and later states SHALL use only the captured values.
REQ-019 The left sample point SHALL be (X-S, Y); the right sample point SHALL be (X+S, Y).
REQ-020 If X < S, the left sample SHALL be skipped (treated as 0), and LATCH SHALL go directly to REQ_R.
REQ-021 If X+S > H_RES-1 or Y > V_RES-1, the affected sample SHALL be skipped and treated as 0.
REQ-022 Address arithmetic SHALL be at least MEM_ADDR_W bits wide, with no truncation for Y <= V_RES-1 and X <= H_RES-1; a shift-add form (Y<<9 + Y<<7) is acceptable for H_RES=640.
REQ-023 In REQ_x, mem_rd SHALL assert with mem_addr valid, then the FSM SHALL enter WAIT_x.
REQ-024 mem_rd and mem_addr SHALL stay constant until the cycle mem_valid=1; mem_rdata SHALL be sampled in that cycle, and mem_rd SHALL drop in the next cycle.
REQ-025 mem_valid received outside WAIT_L/WAIT_R SHALL be ignored.
REQ-026 Read latency SHALL be unbounded, with no timeout; zero-wait response (mem_valid in the first WAIT cycle) SHALL work.
REQ-027 In DONE, bit_on SHALL be set to (left_hit OR right_hit) and held until the next DONE; the FSM SHALL then return to IDLE.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 A frame_start in any state other than IDLE SHALL be dropped and SHALL pulse overrun; the current check SHALL continue unaffected.
REQ-030 If frame_start and DONE coincide, the edge SHALL count as an overrun.

Reset
REQ-031 When Reset_n=0 at a Clk edge, the FSM SHALL go to IDLE and bit_on, mem_rd, busy, overrun and the synchroniser flops SHALL clear to 0; mem_addr SHALL reset to 0.
REQ-032 Reset mid-transaction SHALL abandon the outstanding read, and a late mem_valid after reset SHALL be ignored.

Structure
REQ-033 A package ball_pkg SHALL hold the FSM state enum, H_RES/V_RES defaults and MEM_ADDR_W.
REQ-034 The synchroniser/edge detector SHALL be one sub-module, sync_edge; all other logic SHALL be flat.

Verification
REQ-035 Ball (320,240), S=4, all-zero bitmap, frame edge -> reads at addresses 153916 then 153924, then bit_on=0.
REQ-036 Same ball, bitmap bit 153924 set, mem_valid latency 3 cycles -> mem_rd held 3 cycles per read; bit_on=1 after DONE and held across the next frame until recomputed.
REQ-037 Ball (2,240), S=4 -> only one read, at address 153606; the left sample is skipped.
REQ-038 Second frame_clk edge while in WAIT_R -> overrun pulses once, the check completes normally, and no extra reads occur.
REQ-039 Reset_n=0 during WAIT_L, then a stray mem_valid -> FSM in IDLE, mem_rd=0, bit_on=0, stray ignored.
REQ-040 mem_valid asserted in IDLE with mem_rdata=1 -> no state change and bit_on unchanged.
